mac_dot_product: RTL and testbench

- Parametrised successor to the fixed 8-bit two-term multiply-accumulate datapath.
- Computes the dot product of a LEN-element vector pair streamed one element pair per beat.
- Supports a generic element width and run-time signed/unsigned mode, with valid/ready handshakes on input and output.
- Sits between the operand source and the result consumer. The controller FSM is a sub-module; the multiply and accumulate stages are inline.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_dot_product_if.sv | 34 +++
 rtl/mac_fsm.sv | 87 ++++++++
 rtl/mac_dot_product.sv | 71 +++++++
 tb/tb_mac_dot_product.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the dot-product MAC.
// Imported by the interface, controller and datapath.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int len);
    return 2 * dw + clog2(len);
  endfunction

endpackage

// File: rtl/mac_dot_product_if.sv
// Operand-in / result-out handshake bundle for mac_dot_product.
// master = source/consumer side, slave = the MAC.
interface mac_dot_product_if #(
  parameter int DATA_W = 8,
  parameter int LEN    = 2
);
  import mac_pkg::*;

  localparam int ACC_W = acc_w(DATA_W, LEN);

  logic              start;
  logic              signed_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ACC_W-1:0]  out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output start, signed_mode, in_valid,
    output a, b, out_ready,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  start, signed_mode, in_valid,
    input  a, b, out_ready,
    output in_ready, out, out_valid, busy
  );

endinterface

// File: rtl/mac_fsm.sv
// Sequencing for the MAC: state, beat count, handshake flags
// and accumulator clear / beat strobes.
module mac_fsm
  import mac_pkg::*;
#(
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic busy,
  output logic out_valid,
  output logic acc_clr,
  output logic beat
);

  localparam int CNT_W = (LEN > 1) ? clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // START is honoured in IDLE, or in HOLD only alongside the result transfer
  assign acc_clr = start &
    ((state == IDLE) | ((state == HOLD) & out_ready));
  assign beat = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              state    <= DRAIN;
              cnt      <= '0;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state    <= RUN;
              cnt      <= '0;
              in_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mac_dot_product.sv
// Streaming dot product: registered multiply, then accumulate.
// Full-precision accumulator, signed or unsigned per vector.
module mac_dot_product
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN    = 2
) (
  input logic          clk,
  input logic          nrst,
  mac_dot_product_if.slave bus
);

  localparam int ACC_W = acc_w(DATA_W, LEN);
  localparam int PW    = 2 * DATA_W;

  logic             acc_clr;
  logic             beat;
  logic             mode;
  logic             pvld;
  logic [PW-1:0]    mul_u;
  logic [PW-1:0]    mul_s;
  logic [ACC_W-1:0] prod_next;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc;

  mac_fsm #(.LEN(LEN)) u_fsm (
    .clk       (clk),
    .nrst      (nrst),
    .start     (bus.start),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .busy      (bus.busy),
    .out_valid (bus.out_valid),
    .acc_clr   (acc_clr),
    .beat      (beat)
  );

  assign mul_u = {{DATA_W{1'b0}}, bus.a} *
                 {{DATA_W{1'b0}}, bus.b};
  assign mul_s = $signed({{DATA_W{bus.a[DATA_W-1]}}, bus.a}) *
                 $signed({{DATA_W{bus.b[DATA_W-1]}}, bus.b});

  // extension is resolved at stage 1 so stage 2 is a plain add
  assign prod_next = mode ? ACC_W'($signed(mul_s))
                          : ACC_W'(mul_u);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      mode <= 1'b0;
      pvld <= 1'b0;
      prod <= '0;
      acc  <= '0;
    end else begin
      pvld <= beat;
      if (beat) begin
        prod <= prod_next;
      end
      if (acc_clr) begin
        acc  <= '0;
        mode <= bus.signed_mode;
      end else if (pvld) begin
        acc <= acc + prod;
      end
    end
  end

  assign bus.out = acc;

endmodule

// File: tb/tb_mac_dot_product.sv
// Directed bench for mac_dot_product: default 8-bit/LEN=2
// instance plus a 4-bit/LEN=1 instance.
module tb_mac_dot_product;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mac_dot_product_if #(.DATA_W(8), .LEN(2)) m ();
  mac_dot_product_if #(.DATA_W(4), .LEN(1)) s ();

  mac_dot_product #(.DATA_W(8), .LEN(2)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (m.slave)
  );

  mac_dot_product #(.DATA_W(4), .LEN(1)) u_small (
    .clk  (clk),
    .nrst (nrst),
    .bus  (s.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic sg);
    m.start = 1'b1;
    m.signed_mode = sg;
    tick;
    m.start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    m.a = a;
    m.b = b;
    m.in_valid = 1'b1;
    while (!m.in_ready && k < 20) begin
      tick;
      k++;
    end
    if (!m.in_ready) chk("in_ready_timeout", 32'(m.in_ready), 1);
    tick;
    m.in_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] exp);
    int k;
    k = 0;
    while (!m.out_valid && k < 20) begin
      tick;
      k++;
    end
    chk({tag, "_valid"}, 32'(m.out_valid), 1);
    chk(tag, 32'(m.out), exp);
  endtask

  task automatic take;
    m.out_ready = 1'b1;
    tick;
    m.out_ready = 1'b0;
    chk("take_valid_low", 32'(m.out_valid), 0);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_out"}, 32'(m.out), 0);
    chk({tag, "_out_valid"}, 32'(m.out_valid), 0);
    chk({tag, "_in_ready"}, 32'(m.in_ready), 0);
    chk({tag, "_busy"}, 32'(m.busy), 0);
  endtask

  task automatic small_vec(input string tag, input logic sg,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [31:0] exp);
    s.start = 1'b1;
    s.signed_mode = sg;
    tick;
    s.start = 1'b0;
    chk({tag, "_in_ready"}, 32'(s.in_ready), 1);
    s.a = a;
    s.b = b;
    s.in_valid = 1'b1;
    tick;
    s.in_valid = 1'b0;
    chk({tag, "_lat0"}, 32'(s.out_valid), 0);
    tick;
    chk({tag, "_lat1"}, 32'(s.out_valid), 1);
    chk(tag, 32'(s.out), exp);
    s.out_ready = 1'b1;
    tick;
    s.out_ready = 1'b0;
    chk({tag, "_taken"}, 32'(s.out_valid), 0);
  endtask

  initial begin
    m.start = 0; m.signed_mode = 0; m.in_valid = 0;
    m.a = 0; m.b = 0; m.out_ready = 0;
    s.start = 0; s.signed_mode = 0; s.in_valid = 0;
    s.a = 0; s.b = 0; s.out_ready = 0;

    tick;
    tick;
    reset_state("por");
    nrst = 1'b1;
    tick;

    // reset from mid-RUN, then a clean vector
    go(1'b0);
    beat(8'd5, 8'd5);
    nrst = 1'b0;
    tick;
    tick;
    reset_state("mid_rst");
    nrst = 1'b1;
    tick;
    go(1'b0);
    beat(8'd2, 8'd2);
    beat(8'd3, 8'd3);
    result("after_rst", 32'd13);
    take;

    // unsigned basic + latency
    go(1'b0);
    beat(8'd3, 8'd4);
    beat(8'd5, 8'd6);
    chk("lat_edge1", 32'(m.out_valid), 0);
    tick;
    chk("lat_edge2", 32'(m.out_valid), 1);
    chk("uns_42", 32'(m.out), 32'h0002A);
    take;

    // unsigned extremes
    go(1'b0);
    beat(8'd255, 8'd255);
    beat(8'd255, 8'd255);
    result("uns_max", 32'h1FC02);
    take;
    go(1'b0);
    beat(8'd0, 8'd255);
    beat(8'd255, 8'd0);
    result("uns_zero", 32'd0);
    take;

    // signed
    go(1'b1);
    beat(8'h80, 8'h80);
    beat(8'h80, 8'h80);
    result("sgn_min", 32'h08000);
    take;
    go(1'b1);
    beat(8'hFD, 8'd7);
    m.signed_mode = 1'b0;
    beat(8'd2, 8'd5);
    result("sgn_toggle", 32'h1FFF5);
    take;

    // input gap
    go(1'b0);
    beat(8'd3, 8'd4);
    for (int i = 0; i < 3; i++) begin
      chk("gap_busy", 32'(m.busy), 1);
      tick;
    end
    beat(8'd5, 8'd6);
    result("gap_42", 32'h0002A);
    take;

    // output stall with ignored START, then back-to-back
    go(1'b0);
    beat(8'd7, 8'd8);
    beat(8'd1, 8'd2);
    result("hold", 32'd58);
    for (int i = 0; i < 5; i++) begin
      m.start = 1'b1;
      tick;
      chk("hold_out", 32'(m.out), 32'd58);
      chk("hold_valid", 32'(m.out_valid), 1);
    end
    m.out_ready = 1'b1;
    tick;
    m.out_ready = 1'b0;
    m.start = 1'b0;
    chk("b2b_in_ready", 32'(m.in_ready), 1);
    chk("b2b_valid_low", 32'(m.out_valid), 0);
    beat(8'd1, 8'd1);
    beat(8'd1, 8'd1);
    result("b2b", 32'd2);
    take;
    chk("idle_busy", 32'(m.busy), 0);

    // LEN=1, DATA_W=4
    small_vec("s_uns", 1'b0, 4'hF, 4'hF, 32'd225);
    small_vec("s_sgn", 1'b1, 4'h8, 4'h8, 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
